alu_pipe: RTL

// - Execution unit fed by the RS issue port; produces CDB broadcasts (the rs_fi/rs_value/rs_rob_id bus consumed by RS/LSB/ROB).
// - 2-stage pipeline: E1 latches issued op, E2 computes and registers CDB result; accepts one op every cycle, no backpressure.
// - Branch/compare ops produce 0/1 in value; ROB resolves branch from value.

---
 rtl/alu_pipe_pkg.sv | 45 ++++
 rtl/alu_pipe_if.sv | 25 ++
 rtl/alu_pipe_core.sv | 38 +++
 rtl/alu_pipe.sv | 58 +++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - widths, op codes and pipeline stage records for the ALU pipe
package alu_pipe_pkg;

  localparam int TYPE_W = 5;
  localparam int ROB_W  = 4;
  localparam int DATA_W = 32;

  typedef enum logic [TYPE_W-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_BEQ  = 5'd10,
    ALU_BNE  = 5'd11,
    ALU_BLT  = 5'd12,
    ALU_BGE  = 5'd13,
    ALU_BLTU = 5'd14,
    ALU_BGEU = 5'd15
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic [TYPE_W-1:0] op;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [ROB_W-1:0]  tag;
  } e1_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] value;
    logic [ROB_W-1:0]  tag;
  } e2_t;

  function automatic logic [DATA_W-1:0] flag(input logic cond);
    return {{(DATA_W-1){1'b0}}, cond};
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - RS issue port and CDB broadcast bundle
interface alu_pipe_if;
  import alu_pipe_pkg::*;

  logic              alu_input;
  logic [TYPE_W-1:0] arith_type;
  logic [DATA_W-1:0] alu_r1_val;
  logic [DATA_W-1:0] alu_r2_val;
  logic [ROB_W-1:0]  inst_rob_id;

  logic              alu_fi;
  logic [DATA_W-1:0] alu_value;
  logic [ROB_W-1:0]  alu_rob_id;

  modport master (
    output alu_input, arith_type, alu_r1_val, alu_r2_val, inst_rob_id,
    input  alu_fi, alu_value, alu_rob_id
  );

  modport slave (
    input  alu_input, arith_type, alu_r1_val, alu_r2_val, inst_rob_id,
    output alu_fi, alu_value, alu_rob_id
  );

endinterface

// File: rtl/alu_pipe_core.sv
// rtl/alu_pipe_core.sv - combinational ALU: (op, a, b) -> result
module alu_pipe_core
  import alu_pipe_pkg::*;
(
  input  logic [TYPE_W-1:0] arith_type,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (arith_type)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  result = flag($signed(a) < $signed(b));
      ALU_SLTU: result = flag(a < b);
      ALU_BEQ:  result = flag(a == b);
      ALU_BNE:  result = flag(a != b);
      ALU_BLT:  result = flag($signed(a) < $signed(b));
      ALU_BGE:  result = flag($signed(a) >= $signed(b));
      ALU_BLTU: result = flag(a < b);
      ALU_BGEU: result = flag(a >= b);
      // Undefined codes still broadcast, with a zero result, so the ROB never loses a tag.
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage ALU: E1 latches the issued op, E2 registers the CDB broadcast
module alu_pipe
  import alu_pipe_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      rob_clear,
  alu_pipe_if.slave bus
);

  e1_t               e1_q, e1_d;
  e2_t               e2_q, e2_d;
  logic [DATA_W-1:0] core_result;

  alu_pipe_core u_core (
    .arith_type (e1_q.op),
    .a          (e1_q.r1),
    .b          (e1_q.r2),
    .result     (core_result)
  );

  always_comb begin
    e1_d = e1_q;
    e2_d = e2_q;
    if (rdy_in) begin
      if (rob_clear) begin
        // Flush kills both stages on the same edge; the op offered this cycle is dropped too.
        e1_d.valid = 1'b0;
        e2_d.valid = 1'b0;
      end else begin
        e1_d.valid = bus.alu_input;
        e1_d.op    = bus.arith_type;
        e1_d.r1    = bus.alu_r1_val;
        e1_d.r2    = bus.alu_r2_val;
        e1_d.tag   = bus.inst_rob_id;
        e2_d.valid = e1_q.valid;
        e2_d.value = core_result;
        e2_d.tag   = e1_q.tag;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      e1_q <= '0;
      e2_q <= '0;
    end else begin
      e1_q <= e1_d;
      e2_q <= e2_d;
    end
  end

  assign bus.alu_fi     = e2_q.valid;
  assign bus.alu_value  = e2_q.value;
  assign bus.alu_rob_id = e2_q.tag;

endmodule
